// File: rtl/conv1d_pkg.sv
// rtl/conv1d_pkg.sv - command codes, FSM states and status bits for conv1d_lanes
package conv1d_pkg;

    localparam logic [6:0] CMD_INFO       = 7'd0;
    localparam logic [6:0] CMD_WR_INPUT   = 7'd1;
    localparam logic [6:0] CMD_WR_FILTER  = 7'd2;
    localparam logic [6:0] CMD_OFFSET     = 7'd3;
    localparam logic [6:0] CMD_DEPTH      = 7'd5;
    localparam logic [6:0] CMD_START      = 7'd6;
    localparam logic [6:0] CMD_QUANT      = 7'd7;
    localparam logic [6:0] CMD_START_X    = 7'd8;
    localparam logic [6:0] CMD_STATUS     = 7'd9;
    localparam logic [6:0] CMD_BIAS       = 7'd12;
    localparam logic [6:0] CMD_MULT       = 7'd13;
    localparam logic [6:0] CMD_SHIFT      = 7'd14;
    localparam logic [6:0] CMD_ACT_MIN    = 7'd15;
    localparam logic [6:0] CMD_ACT_MAX    = 7'd16;
    localparam logic [6:0] CMD_OUT_OFFSET = 7'd17;
    localparam logic [6:0] CMD_ABORT      = 7'd19;
    localparam logic [6:0] CMD_RAW        = 7'd20;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_FIN
    } state_t;

endpackage

// File: rtl/conv1d_lanes_quant.sv
// rtl/conv1d_lanes_quant.sv - requantises the raw accumulator into the activation range
module quant (
    input  logic [31:0] acc,
    input  logic [31:0] bias,
    input  logic [31:0] multiplier,
    input  logic [31:0] shift,
    input  logic [31:0] act_min,
    input  logic [31:0] act_max,
    input  logic [31:0] offset,
    output logic [31:0] q
);
    logic signed [31:0] biased;
    logic signed [31:0] y;
    logic signed [63:0] prod;
    logic signed [63:0] scaled;
    logic [5:0]         sh;

    always_comb begin
        biased = $signed(acc) + $signed(bias);
        prod   = 64'(biased) * 64'($signed(multiplier));
        // shifts beyond the product width saturate to the sign
        sh     = (shift > 32'd63) ? 6'd63 : shift[5:0];
        scaled = prod >>> sh;
        y      = 32'(scaled) + $signed(offset);
        if (y > $signed(act_max)) begin
            q = act_max;
        end else if (y < $signed(act_min)) begin
            q = act_min;
        end else begin
            q = y;
        end
    end

endmodule

// File: rtl/conv1d_lanes.sv
// rtl/conv1d_lanes.sv - command-driven 1-D convolution engine, LANES MACs per accumulate cycle
module conv1d_lanes
    import conv1d_pkg::*;
#(
    parameter int KERNEL_LEN   = 8,
    parameter int MAX_CHANNELS = 128,
    parameter int LANES        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [6:0]  cmd,
    input  logic [31:0] inp0,
    input  logic [31:0] inp1,
    output logic [31:0] ret,
    output logic        busy
);
    localparam int BUF_DEPTH = KERNEL_LEN * MAX_CHANNELS;
    localparam int AW        = $clog2(BUF_DEPTH);
    localparam int SW        = AW + 1;

    logic [7:0]         in_buf   [BUF_DEPTH];
    logic [7:0]         filt_buf [BUF_DEPTH];
    state_t             state;
    logic [31:0]        acc;
    logic               done, err;
    logic [31:0]        input_offset, input_depth, start_x;
    logic [31:0]        bias, out_mult, out_shift, act_min, act_max, out_offset;
    logic [31:0]        run_offset;
    logic [SW-1:0]      run_size, k_addr, in_addr, in_next;
    logic [7:0]         f_lat [LANES];
    logic [7:0]         x_lat [LANES];
    logic [31:0]        lane_idx [LANES];
    logic [31:0]        size_req, in_sum, quant_q;
    logic               start_bad;
    logic signed [31:0] mac_sum;

    always_comb begin
        size_req  = 32'(KERNEL_LEN) * input_depth;
        start_bad = (input_depth == 32'd0) || (input_depth > 32'(MAX_CHANNELS)) ||
                    (start_x >= 32'(KERNEL_LEN)) || ((size_req & 32'(LANES - 1)) != 32'd0);
    end

    // each lane wraps on its own so the window never reads past size
    always_comb begin
        in_sum  = 32'(in_addr) + 32'(LANES);
        in_next = SW'((in_sum >= 32'(run_size)) ? in_sum - 32'(run_size) : in_sum);
        mac_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_idx[i] = (32'(in_addr) + 32'(i) >= 32'(run_size)) ?
                          32'(in_addr) + 32'(i) - 32'(run_size) : 32'(in_addr) + 32'(i);
            mac_sum = mac_sum + 32'($signed(f_lat[i])) *
                      (32'($signed(x_lat[i])) + $signed(run_offset));
        end
    end

    always_ff @(posedge clk) begin
        if (en && state == S_IDLE && (cmd == CMD_WR_INPUT || cmd == CMD_WR_FILTER)) begin
            for (int j = 0; j < 4; j++) begin
                if ({1'b0, inp0} + 33'(j) < 33'(BUF_DEPTH)) begin
                    if (cmd == CMD_WR_INPUT) in_buf[AW'(inp0 + 32'(j))] <= inp1[8*j +: 8];
                    else                     filt_buf[AW'(inp0 + 32'(j))] <= inp1[8*j +: 8];
                end
            end
        end
    end

    quant u_quant (
        .acc        (acc),
        .bias       (bias),
        .multiplier (out_mult),
        .shift      (out_shift),
        .act_min    (act_min),
        .act_max    (act_max),
        .offset     (out_offset),
        .q          (quant_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;  busy <= 1'b0;  ret <= '0;  acc <= '0;
            done <= 1'b1;  err <= 1'b0;
            input_offset <= '0;  input_depth <= '0;  start_x <= '0;
            bias <= '0;  out_mult <= '0;  out_shift <= '0;
            act_min <= '0;  act_max <= '0;  out_offset <= '0;
            run_offset <= '0;  run_size <= '0;  k_addr <= '0;  in_addr <= '0;
            for (int i = 0; i < LANES; i++) begin
                f_lat[i] <= '0;
                x_lat[i] <= '0;
            end
        end else if (en) begin
            case (state)
                S_IDLE: ;
                S_LOAD: begin
                    for (int i = 0; i < LANES; i++) begin
                        f_lat[i] <= filt_buf[AW'(32'(k_addr) + 32'(i))];
                        x_lat[i] <= in_buf[AW'(lane_idx[i])];
                    end
                    state <= S_MAC;
                end
                S_MAC: begin
                    acc     <= acc + mac_sum;
                    k_addr  <= k_addr + SW'(LANES);
                    in_addr <= in_next;
                    state   <= (32'(k_addr) + 32'(LANES) >= 32'(run_size)) ? S_FIN : S_LOAD;
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            // commands run alongside FSM progress; abort and start override the step above
            case (cmd)
                CMD_INFO:       ret <= 32'(BUF_DEPTH);
                CMD_WR_INPUT,
                CMD_WR_FILTER:  if (state != S_IDLE) err <= 1'b1;
                CMD_OFFSET:     input_offset <= inp1;
                CMD_DEPTH:      input_depth <= inp1;
                CMD_START: begin
                    if (state != S_IDLE) begin
                        err <= 1'b1;
                    end else if (start_bad) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end else begin
                        acc        <= '0;
                        err        <= 1'b0;
                        done       <= 1'b0;
                        k_addr     <= '0;
                        in_addr    <= SW'(start_x * input_depth);
                        run_size   <= SW'(size_req);
                        run_offset <= input_offset;
                        busy       <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                CMD_QUANT:      ret <= quant_q;
                CMD_START_X:    start_x <= inp1;
                CMD_STATUS: begin
                    ret            <= '0;
                    ret[STAT_ERR]  <= err;
                    ret[STAT_DONE] <= done;
                end
                CMD_BIAS:       bias <= inp1;
                CMD_MULT:       out_mult <= inp1;
                CMD_SHIFT:      out_shift <= inp1;
                CMD_ACT_MIN:    act_min <= inp1;
                CMD_ACT_MAX:    act_max <= inp1;
                CMD_OUT_OFFSET: out_offset <= inp1;
                CMD_ABORT: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                CMD_RAW:        ret <= acc;
                default:        ret <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_lanes.sv
// tb/tb_conv1d_lanes.sv - directed self-checking bench for conv1d_lanes
module tb_conv1d_lanes;
    logic        clk = 1'b0;
    logic        reset, en;
    logic [6:0]  cmd;
    logic [31:0] inp0, inp1, ret, ret16;
    logic        busy, busy16, seen16;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    byte         fm [24];
    byte         xm [24];

    always #5 clk = ~clk;

    conv1d_lanes #(.KERNEL_LEN(8), .MAX_CHANNELS(128), .LANES(8)) dut (
        .clk(clk), .reset(reset), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
        .ret(ret), .busy(busy)
    );

    conv1d_lanes #(.KERNEL_LEN(8), .MAX_CHANNELS(128), .LANES(16)) dut16 (
        .clk(clk), .reset(reset), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
        .ret(ret16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [6:0] c, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; cmd = c; inp0 = a; inp1 = d;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic load_bufs(input int words);
        for (int w = 0; w < words; w++) begin
            issue(7'd1, 32'(4*w), {xm[4*w+3], xm[4*w+2], xm[4*w+1], xm[4*w]});
            issue(7'd2, 32'(4*w), {fm[4*w+3], fm[4*w+2], fm[4*w+1], fm[4*w]});
        end
    endtask

    task automatic config_run(input int depth, input int sx, input int off);
        issue(7'd5, 0, 32'(depth));
        issue(7'd8, 0, 32'(sx));
        issue(7'd3, 0, 32'(off));
    endtask

    task automatic poll_done(input string tag, input int start_cyc, input int exp_cyc);
        int c;
        c = start_cyc;
        while (busy && c < 200) begin
            issue(7'd9, 0, 0);
            if (busy16) seen16 = 1'b1;
            c++;
        end
        check({tag, "_cycles"}, 32'(c), 32'(exp_cyc));
    endtask

    task automatic run(input string tag, input int exp_cyc);
        issue(7'd6, 0, 0);
        poll_done(tag, 0, exp_cyc);
    endtask

    function automatic int model(input int depth, input int sx, input int off, input int upto);
        int size, a;
        size = 8 * depth;
        a = 0;
        for (int j = 0; j < upto; j++)
            a += int'(fm[j]) * (int'(xm[(sx * depth + j) % size]) + off);
        return a;
    endfunction

    initial begin
        en = 1'b0; cmd = '0; inp0 = '0; inp1 = '0; seen16 = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("reset_busy", 32'(busy), 32'd0);
        issue(7'd9, 0, 0);   check("reset_status", ret, 32'd1);
        issue(7'd20, 0, 0);  check("reset_acc", ret, 32'd0);
        issue(7'd0, 0, 0);   check("buf_depth", ret, 32'd1024);
        issue(7'd3, 0, 5);   check("ret_held", ret, 32'd1024);
        issue(7'd4, 0, 0);   check("unknown_cmd", ret, 32'd0);

        config_run(0, 0, 0);
        issue(7'd6, 0, 0);   check("rej_depth0_busy", 32'(busy), 32'd0);
        issue(7'd9, 0, 0);   check("rej_depth0_status", ret, 32'd3);
        config_run(129, 0, 0);
        issue(7'd6, 0, 0);
        issue(7'd9, 0, 0);   check("rej_depth129_status", ret, 32'd3);
        config_run(128, 8, 0);
        issue(7'd6, 0, 0);
        issue(7'd9, 0, 0);   check("rej_startx8_status", ret, 32'd3);

        for (int j = 0; j < 8; j++) begin
            xm[j] = byte'(j + 1);
            fm[j] = 8'sd1;
        end
        load_bufs(2);
        config_run(1, 0, 0);
        run("basic", 3);
        issue(7'd9, 0, 0);   check("basic_status", ret, 32'd1);
        issue(7'd20, 0, 0);  check("basic_acc", ret, 32'd36);

        issue(7'd12, 0, 4);
        issue(7'd13, 0, 3);
        issue(7'd14, 0, 1);
        issue(7'd17, 0, 10);
        issue(7'd15, 0, -32'sd100);
        issue(7'd16, 0, 1000);
        issue(7'd7, 0, 0);   check("quant_mid", ret, 32'd70);
        issue(7'd16, 0, 50);
        issue(7'd7, 0, 0);   check("quant_clamp_max", ret, 32'd50);
        issue(7'd15, 0, 80);
        issue(7'd16, 0, 1000);
        issue(7'd7, 0, 0);   check("quant_clamp_min", ret, 32'd80);

        issue(7'd1, 1022, 32'hFFFF_FFFF);
        issue(7'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run("oob_rerun", 3);
        issue(7'd20, 0, 0);  check("oob_acc", ret, 32'd36);

        fm[0] = 8'sd1;
        for (int j = 1; j < 8; j++) fm[j] = 8'sd0;
        issue(7'd2, 0, {fm[3], fm[2], fm[1], fm[0]});
        issue(7'd2, 4, {fm[7], fm[6], fm[5], fm[4]});
        config_run(1, 3, 128);
        run("wrap", 3);
        issue(7'd20, 0, 0);  check("wrap_acc", ret, 32'd132);

        for (int j = 0; j < 24; j++) begin
            fm[j] = byte'(j * 37 + 5);
            xm[j] = byte'(j * 91 + 200);
        end
        load_bufs(6);
        config_run(3, 1, -7);
        seen16 = 1'b0;
        run("depth3", 7);
        issue(7'd20, 0, 0);  check("depth3_acc", ret, 32'(model(3, 1, -7, 24)));
        issue(7'd9, 0, 0);
        check("lanes16_status", ret16, 32'd3);
        check("lanes16_busy", 32'(seen16), 32'd0);

        issue(7'd6, 0, 0);
        issue(7'd9, 0, 0);
        issue(7'd6, 0, 0);
        issue(7'd3, 0, 100);
        poll_done("restart", 3, 7);
        issue(7'd20, 0, 0);  check("restart_acc", ret, 32'(model(3, 1, -7, 24)));
        issue(7'd9, 0, 0);   check("restart_status", ret, 32'd3);

        issue(7'd3, 0, -32'sd7);
        issue(7'd6, 0, 0);
        repeat (3) issue(7'd9, 0, 0);
        issue(7'd19, 0, 0);  check("abort_busy", 32'(busy), 32'd0);
        issue(7'd9, 0, 0);   check("abort_status", ret, 32'd1);
        issue(7'd20, 0, 0);  check("abort_partial", ret, 32'(model(3, 1, -7, 16)));

        issue(7'd6, 0, 0);
        issue(7'd9, 0, 0);
        #1 reset = 1'b1;
        #1 check("rst_mac_busy", 32'(busy), 32'd0);
        #1 reset = 1'b0;
        issue(7'd9, 0, 0);   check("rst_mac_status", ret, 32'd1);
        issue(7'd20, 0, 0);  check("rst_mac_acc", ret, 32'd0);
        config_run(3, 1, -7);
        run("rerun", 7);
        issue(7'd20, 0, 0);  check("rerun_acc", ret, 32'(model(3, 1, -7, 24)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
